// File: rtl/drp_responder_pkg.sv
// Shared types and width defaults for the DRP responder and its companion DRP bridge.
package drp_responder_pkg;

   localparam int DRP_ADDR_WIDTH_DEF = 9;
   localparam int DRP_DATA_WIDTH_DEF = 16;
   localparam int LAT_CNT_W          = 4;
   localparam int TXN_CNT_W          = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } drp_state_t;

endpackage

// File: rtl/drp_responder_if.sv
// DRP request/response bundle; the master drives strobes, the slave answers with rdy/do.
interface drp_responder_if #(
   parameter int ADDR_W = drp_responder_pkg::DRP_ADDR_WIDTH_DEF,
   parameter int DATA_W = drp_responder_pkg::DRP_DATA_WIDTH_DEF
);
   logic              drp_en;
   logic              drp_we;
   logic [ADDR_W-1:0] drp_addr;
   logic [DATA_W-1:0] drp_di;
   logic [DATA_W-1:0] drp_do;
   logic              drp_rdy;

   modport master (
      output drp_en, drp_we, drp_addr, drp_di,
      input  drp_do, drp_rdy
   );

   modport slave (
      input  drp_en, drp_we, drp_addr, drp_di,
      output drp_do, drp_rdy
   );
endinterface

// File: rtl/drp_responder_reg_bank.sv
// RW register storage plus RW/RO/out-of-range read mux; all effects land on the commit edge.
module drp_responder_reg_bank #(
   parameter int ADDR_W   = 9,
   parameter int W        = 16,
   parameter int NUM_REGS = 32,
   parameter int RO_BASE  = 24,
   parameter logic [W-1:0] RESET_VALUE = '0
) (
   input  logic                          AXI_aclk,
   input  logic                          AXI_sreset,
   input  logic                          commit,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [W-1:0]                  di,
   input  logic [(NUM_REGS-RO_BASE)*W-1:0] status_in,
   output logic [RO_BASE*W-1:0]          regs_out,
   output logic [W-1:0]                  rd_data,
   output logic                          err_addr
);

   localparam int NUM_RO = NUM_REGS - RO_BASE;
   localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

   logic          in_range;
   logic [W-1:0]  rd_value;
   logic [W-1:0]  rd_data_reg;
   logic          err_addr_reg;

   // Full-width compare so upper address bits never alias onto implemented registers.
   assign in_range = ({1'b0, addr} < NUM_REGS_A);

   generate
      for (genvar gi = 0; gi < RO_BASE; gi++) begin : g_rw
         logic [W-1:0] q_reg;
         always_ff @(posedge AXI_aclk or posedge AXI_sreset) begin
            if (AXI_sreset) begin
               q_reg <= RESET_VALUE;
            end else if (commit && we && (addr == ADDR_W'(gi))) begin
               q_reg <= di;
            end
         end
         assign regs_out[gi*W +: W] = q_reg;
      end
   endgenerate

   always_comb begin
      rd_value = '0;
      for (int i = 0; i < RO_BASE; i++) begin
         if (addr == ADDR_W'(i)) rd_value = regs_out[i*W +: W];
      end
      for (int j = 0; j < NUM_RO; j++) begin
         if (addr == ADDR_W'(RO_BASE + j)) rd_value = status_in[j*W +: W];
      end
   end

   // Read data exists only in the completion cycle; otherwise the bus idles at zero.
   always_ff @(posedge AXI_aclk or posedge AXI_sreset) begin
      if (AXI_sreset) begin
         rd_data_reg  <= '0;
         err_addr_reg <= 1'b0;
      end else begin
         rd_data_reg  <= (commit && !we) ? rd_value : '0;
         err_addr_reg <= commit && !in_range;
      end
   end

   assign rd_data  = rd_data_reg;
   assign err_addr = err_addr_reg;

endmodule

// File: rtl/drp_responder.sv
// DRP slave: accepts one request at a time and completes it with a single drp_rdy pulse
// exactly RDY_LATENCY cycles after drp_en.
module drp_responder
   import drp_responder_pkg::*;
#(
   parameter int DRP_ADDR_WIDTH = DRP_ADDR_WIDTH_DEF,
   parameter int DRP_DATA_WIDTH = DRP_DATA_WIDTH_DEF,
   parameter int NUM_REGS       = 32,
   parameter int RO_BASE        = 24,
   parameter int RDY_LATENCY    = 3,
   parameter logic [DRP_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                                       AXI_aclk,
   input  logic                                       AXI_sreset,
   drp_responder_if.slave                             drp,
   output logic [RO_BASE*DRP_DATA_WIDTH-1:0]          regs_out,
   input  logic [(NUM_REGS-RO_BASE)*DRP_DATA_WIDTH-1:0] status_in,
   output logic                                       err_addr,
   output logic                                       err_overlap,
   output logic [TXN_CNT_W-1:0]                       txn_count
);

   drp_state_t                state_reg, state_next;
   logic [LAT_CNT_W-1:0]      lat_cnt_reg, lat_cnt_next;
   logic [DRP_ADDR_WIDTH-1:0] addr_reg;
   logic                      we_reg;
   logic [DRP_DATA_WIDTH-1:0] di_reg;
   logic                      rdy_reg;
   logic                      overlap_reg;
   logic [TXN_CNT_W-1:0]      txn_count_reg;

   logic                      accept;
   logic                      complete;
   logic [DRP_ADDR_WIDTH-1:0] cur_addr;
   logic                      cur_we;
   logic [DRP_DATA_WIDTH-1:0] cur_di;

   assign accept = (state_reg == ST_IDLE) && drp.drp_en;

   // lat_cnt holds the BUSY cycles still to run before the completion edge; drp_rdy is
   // registered, so completion is decided one cycle ahead of the pulse.
   always_comb begin
      state_next   = state_reg;
      lat_cnt_next = lat_cnt_reg;
      complete     = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (drp.drp_en) begin
               if (RDY_LATENCY == 1) begin
                  complete = 1'b1;
               end else begin
                  state_next   = ST_BUSY;
                  lat_cnt_next = LAT_CNT_W'(RDY_LATENCY - 2);
               end
            end
         end
         ST_BUSY: begin
            if (lat_cnt_reg == '0) begin
               complete   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               lat_cnt_next = lat_cnt_reg - LAT_CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A single-cycle request completes before it could be latched, so use the live bus then.
   assign cur_addr = (state_reg == ST_IDLE) ? drp.drp_addr : addr_reg;
   assign cur_we   = (state_reg == ST_IDLE) ? drp.drp_we   : we_reg;
   assign cur_di   = (state_reg == ST_IDLE) ? drp.drp_di   : di_reg;

   always_ff @(posedge AXI_aclk or posedge AXI_sreset) begin
      if (AXI_sreset) begin
         state_reg     <= ST_IDLE;
         lat_cnt_reg   <= '0;
         addr_reg      <= '0;
         we_reg        <= 1'b0;
         di_reg        <= '0;
         rdy_reg       <= 1'b0;
         overlap_reg   <= 1'b0;
         txn_count_reg <= '0;
      end else begin
         state_reg   <= state_next;
         lat_cnt_reg <= lat_cnt_next;
         if (accept) begin
            addr_reg <= drp.drp_addr;
            we_reg   <= drp.drp_we;
            di_reg   <= drp.drp_di;
         end
         rdy_reg     <= complete;
         overlap_reg <= (state_reg == ST_BUSY) && drp.drp_en;
         if (complete) txn_count_reg <= txn_count_reg + TXN_CNT_W'(1);
      end
   end

   drp_responder_reg_bank #(
      .ADDR_W      (DRP_ADDR_WIDTH),
      .W           (DRP_DATA_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .RO_BASE     (RO_BASE),
      .RESET_VALUE (RESET_VALUE)
   ) u_reg_bank (
      .AXI_aclk   (AXI_aclk),
      .AXI_sreset (AXI_sreset),
      .commit     (complete),
      .we         (cur_we),
      .addr       (cur_addr),
      .di         (cur_di),
      .status_in  (status_in),
      .regs_out   (regs_out),
      .rd_data    (drp.drp_do),
      .err_addr   (err_addr)
   );

   assign drp.drp_rdy = rdy_reg;
   assign err_overlap = overlap_reg;
   assign txn_count   = txn_count_reg;

endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder: vector table at latency 3 plus overlap, reset and
// latency-sweep sequences on latency 1/3/15 instances sharing one stimulus bus.
module tb_drp_responder;

   localparam int AW  = 9;
   localparam int W   = 16;
   localparam int NR  = 32;
   localparam int RB  = 24;
   localparam int NRO = NR - RB;
   localparam int NV  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          en   = 1'b0;
   logic          we   = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [W-1:0]  di   = '0;
   logic [NRO*W-1:0] status;

   drp_responder_if #(.ADDR_W(AW), .DATA_W(W)) m3 ();
   drp_responder_if #(.ADDR_W(AW), .DATA_W(W)) m1 ();
   drp_responder_if #(.ADDR_W(AW), .DATA_W(W)) m15 ();

   assign m3.drp_en  = en;   assign m3.drp_we  = we;   assign m3.drp_addr  = addr;   assign m3.drp_di  = di;
   assign m1.drp_en  = en;   assign m1.drp_we  = we;   assign m1.drp_addr  = addr;   assign m1.drp_di  = di;
   assign m15.drp_en = en;   assign m15.drp_we = we;   assign m15.drp_addr = addr;   assign m15.drp_di = di;

   logic [RB*W-1:0] regs3, regs1, regs15;
   logic            ea3, ea1, ea15, eo3, eo1, eo15;
   logic [15:0]     tc3, tc1, tc15;

   drp_responder #(.RDY_LATENCY(3)) dut3 (
      .AXI_aclk(clk), .AXI_sreset(rst), .drp(m3), .regs_out(regs3), .status_in(status),
      .err_addr(ea3), .err_overlap(eo3), .txn_count(tc3));
   drp_responder #(.RDY_LATENCY(1)) dut1 (
      .AXI_aclk(clk), .AXI_sreset(rst), .drp(m1), .regs_out(regs1), .status_in(status),
      .err_addr(ea1), .err_overlap(eo1), .txn_count(tc1));
   drp_responder #(.RDY_LATENCY(15)) dut15 (
      .AXI_aclk(clk), .AXI_sreset(rst), .drp(m15), .regs_out(regs15), .status_in(status),
      .err_addr(ea15), .err_overlap(eo15), .txn_count(tc15));

   int n_pass  = 0;
   int n_total = 0;
   int rdy_cnt3 = 0;

   always @(negedge clk) if (m3.drp_rdy) rdy_cnt3++;

   task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   logic [RB*W-1:0] model;
   int              mcount;

   task automatic model_write(input logic [AW-1:0] a, input logic [W-1:0] d);
      if (int'(a) < RB) model[int'(a)*W +: W] = d;
   endtask

   task automatic txn(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                      output int lat);
      @(posedge clk); #1;
      en = 1'b1; we = w; addr = a; di = d;
      @(posedge clk); #1;
      en = 1'b0;
      lat = 1;
      while (!m3.drp_rdy && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!m3.drp_rdy) lat = 99;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  di;
      logic [W-1:0]  exp_do;
      logic          exp_err;
   } vec_t;

   vec_t vecs [NV];

   initial begin
      int lat, l1, l3, l15, base;

      vecs[0]  = '{1'b1, 9'd5,   16'hA5A5, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 9'd5,   16'h0000, 16'hA5A5, 1'b0};
      vecs[2]  = '{1'b0, 9'd24,  16'h0000, 16'h1234, 1'b0};
      vecs[3]  = '{1'b1, 9'd24,  16'hFFFF, 16'h0000, 1'b0};
      vecs[4]  = '{1'b0, 9'd24,  16'h0000, 16'h1234, 1'b0};
      vecs[5]  = '{1'b0, 9'd40,  16'h0000, 16'h0000, 1'b1};
      vecs[6]  = '{1'b1, 9'd40,  16'h1111, 16'h0000, 1'b1};
      vecs[7]  = '{1'b0, 9'd31,  16'h0000, 16'hBEEF, 1'b0};
      vecs[8]  = '{1'b1, 9'd0,   16'h0001, 16'h0000, 1'b0};
      vecs[9]  = '{1'b0, 9'd0,   16'h0000, 16'h0001, 1'b0};
      vecs[10] = '{1'b1, 9'd23,  16'hCAFE, 16'h0000, 1'b0};
      vecs[11] = '{1'b0, 9'd23,  16'h0000, 16'hCAFE, 1'b0};
      vecs[12] = '{1'b1, 9'd256, 16'h7777, 16'h0000, 1'b1};
      vecs[13] = '{1'b0, 9'd0,   16'h0000, 16'h0001, 1'b0};
      vecs[14] = '{1'b0, 9'd2,   16'h0000, 16'h2222, 1'b0};
      vecs[15] = '{1'b0, 9'd256, 16'h0000, 16'h0000, 1'b1};

      status = '0;
      status[0*W +: W] = 16'h1234;
      status[7*W +: W] = 16'hBEEF;
      model  = '0;
      mcount = 0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy",  384'(m3.drp_rdy), 384'(0));
      check("rst_do",   384'(m3.drp_do),  384'(0));
      check("rst_regs", 384'(regs3),      384'(model));
      check("rst_err",  384'({ea3, eo3}), 384'(0));
      check("rst_txn",  384'(tc3),        384'(0));
      rst = 1'b0;

      // Latency sweep: first request after reset on all three instances
      @(posedge clk); #1;
      en = 1'b1; we = 1'b1; addr = 9'd2; di = 16'h2222;
      @(posedge clk); #1;
      en = 1'b0;
      l1 = 0; l3 = 0; l15 = 0;
      for (int k = 1; k <= 20; k++) begin
         if (m1.drp_rdy  && l1  == 0) l1  = k;
         if (m3.drp_rdy  && l3  == 0) l3  = k;
         if (m15.drp_rdy && l15 == 0) l15 = k;
         @(posedge clk); #1;
      end
      check("lat1",      384'(l1),  384'(1));
      check("lat3",      384'(l3),  384'(3));
      check("lat15",     384'(l15), 384'(15));
      check("lat1_reg",  384'(regs1[2*W +: W]),  384'(16'h2222));
      check("lat15_reg", 384'(regs15[2*W +: W]), 384'(16'h2222));
      check("lat1_txn",  384'(tc1),  384'(1));
      check("lat15_txn", 384'(tc15), 384'(1));
      model_write(9'd2, 16'h2222);
      mcount = 1;
      check("lat3_txn",  384'(tc3),  384'(mcount));

      // Vector table at latency 3
      for (int i = 0; i < NV; i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].di, lat);
         if (vecs[i].we) model_write(vecs[i].addr, vecs[i].di);
         mcount++;
         $display("txn %0d: we=%0d addr=%0d di=%h do=%h err=%0d lat=%0d",
                  i, vecs[i].we, vecs[i].addr, vecs[i].di, m3.drp_do, ea3, lat);
         check($sformatf("v%0d_lat", i), 384'(lat), 384'(3));
         if (!vecs[i].we) check($sformatf("v%0d_do", i), 384'(m3.drp_do), 384'(vecs[i].exp_do));
         check($sformatf("v%0d_err", i),  384'(ea3),   384'(vecs[i].exp_err));
         check($sformatf("v%0d_regs", i), 384'(regs3), 384'(model));
         check($sformatf("v%0d_txn", i),  384'(tc3),   384'(mcount));
         @(posedge clk); #1;
         check($sformatf("v%0d_do_idle", i),  384'(m3.drp_do),  384'(0));
         check($sformatf("v%0d_rdy_idle", i), 384'(m3.drp_rdy), 384'(0));
      end

      // Overlap: second drp_en one cycle later is dropped; drp_en in rdy cycle accepted
      base = rdy_cnt3;
      @(posedge clk); #1;
      en = 1'b1; we = 1'b1; addr = 9'd3; di = 16'h3333;
      @(posedge clk); #1;
      addr = 9'd4; di = 16'h4444;
      @(posedge clk); #1;
      en = 1'b0;
      check("ovl_pulse", 384'(eo3), 384'(1));
      @(posedge clk); #1;
      check("ovl_rdy1", 384'(m3.drp_rdy), 384'(1));
      model_write(9'd3, 16'h3333);
      check("ovl_regs", 384'(regs3), 384'(model));
      en = 1'b1; we = 1'b0; addr = 9'd3;
      @(posedge clk); #1;
      en = 1'b0;
      check("ovl_noerr", 384'(eo3), 384'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ovl_rdy2", 384'(m3.drp_rdy), 384'(1));
      check("ovl_do2",  384'(m3.drp_do),  384'(16'h3333));
      @(posedge clk); #1;
      check("ovl_nrdy", 384'(rdy_cnt3 - base), 384'(2));
      mcount += 2;
      check("ovl_txn",  384'(tc3), 384'(mcount));
      $display("overlap seq: rdy pulses=%0d txn_count=%0d", rdy_cnt3 - base, tc3);

      // Reset one cycle after drp_en of a write: transaction dropped
      @(posedge clk); #1;
      en = 1'b1; we = 1'b1; addr = 9'd6; di = 16'h6666;
      @(posedge clk); #1;
      en = 1'b0;
      rst = 1'b1;
      base = rdy_cnt3;
      model = '0;
      mcount = 0;
      @(posedge clk);
      @(posedge clk); #1;
      check("mrst_regs", 384'(regs3),      384'(model));
      check("mrst_txn",  384'(tc3),        384'(0));
      check("mrst_rdy",  384'(m3.drp_rdy), 384'(0));
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mrst_norrdy", 384'(rdy_cnt3 - base), 384'(0));
      check("mrst_reg6",   384'(regs3[6*W +: W]), 384'(0));
      $display("mid-write reset: rdy pulses=%0d reg6=%h", rdy_cnt3 - base, regs3[6*W +: W]);

      txn(1'b1, 9'd6, 16'h6666, lat);
      model_write(9'd6, 16'h6666);
      mcount = 1;
      check("post_lat",  384'(lat),   384'(3));
      check("post_regs", 384'(regs3), 384'(model));
      check("post_txn",  384'(tc3),   384'(mcount));
      $display("post-reset txn: lat=%0d txn_count=%0d", lat, tc3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
